switch_pulse_gen: RTL and testbench

- Downstream stage of the comparator. Consumes the comparator's `comp` match strobe in the `counter_clk` domain.
- Converts each match into a timed drive signal for one photonic switch.
- Two modes: a fixed-width pulse, or a state toggle. Either is applied after a programmable delay.
- Tracks accepted triggers, and flags triggers that arrive while the block is busy.

---
 rtl/switch_pulse_gen.sv | 127 ++++++++++++
 tb/tb_switch_pulse_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_pulse_gen.sv
// Turns comparator match strobes into a delayed, timed drive for one photonic switch.
// The output is either a fixed-width pulse or a level toggle, and triggers that arrive while busy are flagged.
module switch_pulse_gen #(
    parameter int DLY_W = 7,
    parameter int PW_W  = 7,
    parameter int CNT_W = 16
) (
    input  logic             counter_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             comp,
    input  logic             mode,
    input  logic [DLY_W-1:0] delay,
    input  logic [PW_W-1:0]  width,
    input  logic             clr,
    output logic             sw_out,
    output logic             busy,
    output logic             missed,
    output logic [CNT_W-1:0] pulse_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A zero width still produces a one-cycle pulse.
    function automatic logic [PW_W-1:0] pw_load(input logic [PW_W-1:0] w);
        return (w == '0) ? '0 : w - PW_W'(1);
    endfunction

    logic [1:0]       state;
    logic             comp_d;
    logic             mode_l;
    logic [PW_W-1:0]  pw_l;
    logic [DLY_W-1:0] dcnt;
    logic [PW_W-1:0]  wcnt;
    logic             trig;
    logic             accept;
    logic             reject;

    assign trig   = comp & ~comp_d & en;
    assign accept = trig && (state == ST_IDLE);
    assign reject = trig && (state != ST_IDLE);

    // dcnt is loaded with the full delay and the action fires on the edge after it reaches
    // zero, so the output moves delay+1 edges after the accepting edge.
    always_ff @(posedge counter_clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            sw_out <= 1'b0;
            comp_d <= 1'b0;
            mode_l <= 1'b0;
            pw_l   <= '0;
            dcnt   <= '0;
            wcnt   <= '0;
        end else begin
            comp_d <= comp;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mode_l <= mode;
                        pw_l   <= pw_load(width);
                        dcnt   <= delay;
                        state  <= ST_DELAY;
                        busy   <= 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (!en) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        dcnt  <= '0;
                        wcnt  <= '0;
                        if (!mode_l) sw_out <= 1'b0;
                    end else if (dcnt == '0) begin
                        if (mode_l) begin
                            sw_out <= ~sw_out;
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
                        end else begin
                            sw_out <= 1'b1;
                            wcnt   <= pw_l;
                            state  <= ST_ACTIVE;
                        end
                    end else begin
                        dcnt <= dcnt - DLY_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (!en || wcnt == '0) begin
                        sw_out <= 1'b0;
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        dcnt   <= '0;
                        wcnt   <= '0;
                    end else begin
                        wcnt <= wcnt - PW_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // clr wins over a same-edge increment or missed flag.
    always_ff @(posedge counter_clk or negedge reset) begin
        if (!reset) begin
            pulse_count <= '0;
            missed      <= 1'b0;
        end else if (clr) begin
            pulse_count <= '0;
            missed      <= 1'b0;
        end else begin
            if (accept) pulse_count <= sat_inc(pulse_count);
            if (reject) missed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_switch_pulse_gen.sv
// Directed bench for switch_pulse_gen: per-edge sw_out/busy expectations are queued when a
// trigger is driven and checked as each edge elapses; counters and flags are checked directly.
module tb_switch_pulse_gen;

    logic        clk;
    logic        reset;
    logic        en, comp, mode, clr;
    logic [6:0]  delay, width;
    logic        sw_out, busy, missed;
    logic [15:0] pulse_count;

    logic        en2, comp2, mode2, clr2;
    logic [6:0]  delay2, width2;
    logic        sw_out2, busy2, missed2;
    logic [3:0]  pulse_count2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int k     = 0;

    typedef struct {
        int   cyc;
        logic sw;
        logic bsy;
    } exp_t;
    exp_t sb[$];

    switch_pulse_gen #(.DLY_W(7), .PW_W(7), .CNT_W(16)) dut (
        .counter_clk(clk), .reset(reset), .en(en), .comp(comp), .mode(mode),
        .delay(delay), .width(width), .clr(clr), .sw_out(sw_out), .busy(busy),
        .missed(missed), .pulse_count(pulse_count)
    );

    switch_pulse_gen #(.DLY_W(7), .PW_W(7), .CNT_W(4)) dut_sat (
        .counter_clk(clk), .reset(reset), .en(en2), .comp(comp2), .mode(mode2),
        .delay(delay2), .width(width2), .clr(clr2), .sw_out(sw_out2), .busy(busy2),
        .missed(missed2), .pulse_count(pulse_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic s, input logic b);
        exp_t e;
        e.cyc = c;
        e.sw  = s;
        e.bsy = b;
        sb.push_back(e);
    endtask

    task automatic push_pulse(input int kk, input int d, input int w);
        int wl;
        wl = (w == 0) ? 1 : w;
        for (int e = kk; e <= kk + d; e++) push(e, 1'b0, 1'b1);
        for (int e = kk + d + 1; e <= kk + d + wl; e++) push(e, 1'b1, 1'b1);
        push(kk + d + wl + 1, 1'b0, 1'b0);
    endtask

    task automatic push_toggle(input int kk, input int d, input logic prev);
        for (int e = kk; e <= kk + d; e++) push(e, prev, 1'b1);
        push(kk + d + 1, ~prev, 1'b0);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk($sformatf("sw_out@%0d", e.cyc), 32'(sw_out), 32'(e.sw));
            chk($sformatf("busy@%0d", e.cyc), 32'(busy), 32'(e.bsy));
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; comp = 1'b0; mode = 1'b0; clr = 1'b0;
        delay = 7'd0; width = 7'd0;
        en2 = 1'b1; comp2 = 1'b0; mode2 = 1'b1; clr2 = 1'b0; delay2 = 7'd0; width2 = 7'd0;

        repeat (2) step();
        chk("rst_sw_out", 32'(sw_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_missed", 32'(missed), 32'd0);
        chk("rst_count", 32'(pulse_count), 32'd0);
        reset = 1'b1;
        en = 1'b1; mode = 1'b0; delay = 7'd3; width = 7'd4;
        repeat (2) step();

        // Basic pulse: delay 3, width 4
        comp = 1'b1; k = cyc + 1; push_pulse(k, 3, 4);
        step(); comp = 1'b0;
        repeat (9) step();
        chk("t1_count", 32'(pulse_count), 32'd1);
        chk("t1_missed", 32'(missed), 32'd0);

        // Zero delay and zero width give a one-cycle pulse on the next edge
        delay = 7'd0; width = 7'd0;
        comp = 1'b1; k = cyc + 1; push_pulse(k, 0, 0);
        step(); comp = 1'b0;
        repeat (3) step();
        chk("t2_count", 32'(pulse_count), 32'd2);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_count", 32'(pulse_count), 32'd0);

        // Toggle mode, two triggers
        mode = 1'b1; delay = 7'd2;
        comp = 1'b1; k = cyc + 1; push_toggle(k, 2, 1'b0);
        step(); comp = 1'b0;
        repeat (8) step();
        comp = 1'b1; k = cyc + 1; push_toggle(k, 2, 1'b1);
        step(); comp = 1'b0;
        repeat (5) step();
        chk("t3_count", 32'(pulse_count), 32'd2);
        chk("t3_missed", 32'(missed), 32'd0);

        // Retrigger during DELAY is ignored and flagged
        mode = 1'b0; delay = 7'd5; width = 7'd5;
        comp = 1'b1; k = cyc + 1; push_pulse(k, 5, 5);
        step(); comp = 1'b0;
        repeat (3) step();
        comp = 1'b1; step(); comp = 1'b0;
        repeat (7) step();
        chk("t4_missed", 32'(missed), 32'd1);
        chk("t4_count", 32'(pulse_count), 32'd3);
        clr = 1'b1; step(); clr = 1'b0;
        chk("t4_clr_missed", 32'(missed), 32'd0);
        chk("t4_clr_count", 32'(pulse_count), 32'd0);

        // Trigger on the return-to-IDLE edge counts as missed
        delay = 7'd1; width = 7'd1;
        comp = 1'b1; k = cyc + 1; push_pulse(k, 1, 1); push(k + 4, 1'b0, 1'b0);
        step(); comp = 1'b0;
        repeat (2) step();
        comp = 1'b1; step(); comp = 1'b0;
        step();
        chk("rti_missed", 32'(missed), 32'd1);
        chk("rti_count", 32'(pulse_count), 32'd1);

        // clr on the same edge as an accepted trigger: counters cleared, sequence still runs
        clr = 1'b1; comp = 1'b1; k = cyc + 1; push_pulse(k, 1, 1);
        step(); clr = 1'b0; comp = 1'b0;
        repeat (3) step();
        chk("clrtrig_count", 32'(pulse_count), 32'd0);
        chk("clrtrig_missed", 32'(missed), 32'd0);

        // Held comp gives one trigger; en drop in ACTIVE aborts
        delay = 7'd1; width = 7'd8;
        comp = 1'b1; k = cyc + 1;
        push(k, 1'b0, 1'b1); push(k + 1, 1'b0, 1'b1);
        for (int e = k + 2; e <= k + 5; e++) push(e, 1'b1, 1'b1);
        push(k + 6, 1'b0, 1'b0); push(k + 7, 1'b0, 1'b0);
        repeat (6) step();
        comp = 1'b0; en = 1'b0; step();
        en = 1'b1; step();
        chk("t5_count", 32'(pulse_count), 32'd1);
        chk("t5_missed", 32'(missed), 32'd0);

        // Toggle high, then abort a toggle sequence: level is held
        mode = 1'b1; delay = 7'd0;
        comp = 1'b1; k = cyc + 1; push_toggle(k, 0, 1'b0);
        step(); comp = 1'b0;
        repeat (2) step();
        delay = 7'd4;
        comp = 1'b1; k = cyc + 1;
        for (int e = k; e <= k + 2; e++) push(e, 1'b1, 1'b1);
        push(k + 3, 1'b1, 1'b0); push(k + 4, 1'b1, 1'b0);
        step(); comp = 1'b0;
        repeat (2) step();
        en = 1'b0; step();
        en = 1'b1; step();
        chk("tgl_abort_count", 32'(pulse_count), 32'd3);

        // Saturation on the narrow-counter instance
        for (int i = 0; i < 14; i++) begin
            comp2 = 1'b1; step(); comp2 = 1'b0; step();
        end
        chk("sat_pre", 32'(pulse_count2), 32'hE);
        comp2 = 1'b1; step(); comp2 = 1'b0; step();
        chk("sat_max", 32'(pulse_count2), 32'hF);
        comp2 = 1'b1; step(); comp2 = 1'b0; step();
        chk("sat_hold", 32'(pulse_count2), 32'hF);
        chk("sat_missed", 32'(missed2), 32'd0);

        // Asynchronous reset mid-DELAY in toggle mode with sw_out high
        delay = 7'd6;
        comp = 1'b1; k = cyc + 1; push(k, 1'b1, 1'b1); push(k + 1, 1'b1, 1'b1);
        step(); comp = 1'b0;
        step();
        chk("pre_rst_count", 32'(pulse_count), 32'd4);
        #2 reset = 1'b0;
        #1;
        chk("arst_sw_out", 32'(sw_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_missed", 32'(missed), 32'd0);
        chk("arst_count", 32'(pulse_count), 32'd0);
        chk("arst_count_sat", 32'(pulse_count2), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        reset = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
